// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared FSM state, error codes and checksum width for the frame link.
package uart_frame_pkg;
    typedef enum logic [2:0] {IDLE, RX, TX_LOAD, TX_WAIT, DRAIN} state_t;
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MSGID = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_LEN   = 2'd3;
    localparam int CSUM_W = 16;
endpackage

// File: rtl/uart_frame_link_if.sv
// uart_frame_link_if: byte-level receive/transmit handshake between a UART and the frame link.
interface uart_frame_link_if;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_eop;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy;
    modport master (output rx_byte, rx_byte_valid, rx_eop, tx_busy, input tx_byte, tx_start);
    modport slave  (input rx_byte, rx_byte_valid, rx_eop, tx_busy, output tx_byte, tx_start);
endinterface

// File: rtl/uart_frame_csum.sv
// uart_frame_csum: 16-bit additive byte checksum; clear and add may coincide (sum restarts at the byte).
module uart_frame_csum
    import uart_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_add,
    input  logic [7:0]        i_byte,
    output logic [CSUM_W-1:0] o_sum
);
    logic [CSUM_W-1:0] r_sum;
    always_ff @(posedge clk) begin
        if (rst) r_sum <= '0;
        else     r_sum <= (i_clr ? '0 : r_sum) + (i_add ? CSUM_W'(i_byte) : '0);
    end
    assign o_sum = r_sum;
endmodule

// File: rtl/uart_frame_link.sv
// uart_frame_link: half-duplex framed request/reply link over a byte UART with MSGID, checksum and timeout checks.
// Optional frame counters o_frames_ok/o_frames_bad when UART_FRAME_STATS_EN is defined.
module uart_frame_link
    import uart_frame_pkg::*;
#(
    parameter int          BUFFER_SIZE = 80,
    parameter logic [31:0] MSGID       = 32'h74697277,
    parameter int          CSUM        = 1,
    parameter int          TIMEOUT     = 1200
)(
    input  logic                   clk,
    input  logic                   rst,
    uart_frame_link_if.slave       link,
    input  logic [BUFFER_SIZE-1:0] i_tx_data,
    output logic [BUFFER_SIZE-1:0] o_rx_data,
    output logic                   o_sync,
    output logic                   o_tx_enable,
    output logic [1:0]             o_err
`ifdef UART_FRAME_STATS_EN
    ,
    output logic [15:0]            o_frames_ok,
    output logic [15:0]            o_frames_bad
`endif
);
    localparam int P  = BUFFER_SIZE / 8;
    localparam int N  = P + 2 * CSUM;
    localparam int W  = N * 8;
    localparam int CW = $clog2(N + 1);

    state_t                 r_state, w_state_nxt;
    logic [W-1:0]           r_rx_shift, w_rx_shift;
    logic [CW-1:0]          r_rx_cnt, w_rx_cnt, r_tx_cnt;
    logic [31:0]            r_gap;
    logic [BUFFER_SIZE-1:0] r_tx_shift, r_rx_data;
    logic [7:0]             r_tx_byte, w_tx_byte;
    logic                   r_tx_start, r_tx_enable, r_sync;
    logic [1:0]             r_err, w_err;
    logic [CSUM_W-1:0]      w_rx_sum, w_tx_sum;
    logic                   w_take, w_timeout, w_accept, w_reject, w_load, w_sent, w_drained;

    // A byte arriving with rx_eop is folded in before the frame is judged.
    assign w_take     = link.rx_byte_valid && (r_state == IDLE || (r_state == RX && r_rx_cnt < CW'(N)));
    assign w_rx_shift = w_take ? {r_rx_shift[W-9:0], link.rx_byte} : r_rx_shift;
    assign w_rx_cnt   = r_rx_cnt + CW'(w_take);
    assign w_err      = (w_rx_cnt != CW'(N))                           ? ERR_LEN   :
                        (w_rx_shift[W-1 -: 32] != MSGID)               ? ERR_MSGID :
                        (CSUM != 0 && w_rx_shift[15:0] != w_rx_sum)    ? ERR_CSUM  : ERR_NONE;
    assign w_timeout  = (TIMEOUT != 0) && r_state == RX && !link.rx_byte_valid && !link.rx_eop
                        && r_gap >= 32'(TIMEOUT - 1);
    assign w_tx_byte  = (r_tx_cnt < CW'(P))  ? r_tx_shift[BUFFER_SIZE-1 -: 8] :
                        (r_tx_cnt == CW'(P)) ? w_tx_sum[15:8] : w_tx_sum[7:0];

    uart_frame_csum u_rx_csum (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == IDLE),
        .i_add (w_take && r_rx_cnt < CW'(P)),
        .i_byte(link.rx_byte),
        .o_sum (w_rx_sum)
    );

    uart_frame_csum u_tx_csum (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept),
        .i_add (w_load && r_tx_cnt < CW'(P)),
        .i_byte(r_tx_shift[BUFFER_SIZE-1 -: 8]),
        .o_sum (w_tx_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_load      = 1'b0;
        w_sent      = 1'b0;
        w_drained   = 1'b0;
        case (r_state)
            IDLE:    w_state_nxt = link.rx_byte_valid ? RX : IDLE;
            RX: begin
                w_accept    = link.rx_eop && w_err == ERR_NONE;
                w_reject    = link.rx_eop && w_err != ERR_NONE;
                w_state_nxt = w_accept ? TX_LOAD : (w_reject || w_timeout) ? IDLE : RX;
            end
            TX_LOAD: begin
                w_load      = !link.tx_busy;
                w_state_nxt = w_load ? TX_WAIT : TX_LOAD;
            end
            TX_WAIT: begin
                w_sent      = link.tx_busy;
                w_state_nxt = !w_sent ? TX_WAIT : (r_tx_cnt == CW'(N - 1)) ? DRAIN : TX_LOAD;
            end
            DRAIN: begin
                w_drained   = !link.tx_busy;
                w_state_nxt = w_drained ? IDLE : DRAIN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_shift  <= '0;
            r_rx_cnt    <= '0;
            r_gap       <= '0;
            r_tx_shift  <= '0;
            r_tx_cnt    <= '0;
            r_rx_data   <= '0;
            r_tx_byte   <= '0;
            r_tx_start  <= 1'b0;
            r_tx_enable <= 1'b0;
            r_sync      <= 1'b0;
            r_err       <= ERR_NONE;
        end else begin
            r_rx_shift <= w_rx_shift;
            r_rx_cnt   <= (w_state_nxt == RX) ? w_rx_cnt : '0;
            r_gap      <= (link.rx_byte_valid || r_state != RX) ? '0 : r_gap + 32'd1;
            r_sync     <= w_accept;
            if (w_accept) begin
                r_rx_data   <= w_rx_shift[W-1 -: BUFFER_SIZE];
                r_tx_shift  <= i_tx_data;
                r_tx_cnt    <= '0;
                r_tx_enable <= 1'b1;
                r_err       <= ERR_NONE;
            end
            if (w_reject)  r_err <= w_err;
            if (w_timeout) r_err <= ERR_LEN;
            if (w_load) begin
                r_tx_byte  <= w_tx_byte;
                r_tx_start <= 1'b1;
            end
            if (w_sent) begin
                r_tx_start <= 1'b0;
                r_tx_shift <= {r_tx_shift[BUFFER_SIZE-9:0], 8'h00};
                r_tx_cnt   <= r_tx_cnt + CW'(1);
            end
            if (w_drained) r_tx_enable <= 1'b0;
        end
    end

`ifdef UART_FRAME_STATS_EN
    logic [15:0] r_frames_ok, r_frames_bad;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames_ok  <= '0;
            r_frames_bad <= '0;
        end else begin
            r_frames_ok  <= r_frames_ok + 16'(w_accept);
            r_frames_bad <= r_frames_bad + 16'(w_reject || w_timeout);
        end
    end
    assign o_frames_ok  = r_frames_ok;
    assign o_frames_bad = r_frames_bad;
`endif

    assign link.tx_byte  = r_tx_byte;
    assign link.tx_start = r_tx_start;
    assign o_rx_data     = r_rx_data;
    assign o_sync        = r_sync;
    assign o_tx_enable   = r_tx_enable;
    assign o_err         = r_err;
endmodule

// File: tb/tb_uart_frame_link.sv
// tb_uart_frame_link: directed bench with a CSUM=0 instance (u0) and a default CSUM=1 instance (u1).
module tb_uart_frame_link;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_frame_link_if if0 ();
    uart_frame_link_if if1 ();

    logic [79:0] txd0, txd1, rxd0, rxd1;
    logic        sync0, sync1, en0, en1;
    logic [1:0]  err0, err1;
    logic [7:0]  q0[$], q1[$];
    int          nsync0 = 0, nsync1 = 0;
    int          n_checks = 0, n_fail = 0;
    int          base;

    localparam logic [79:0] F0  = 80'h74697277_0102030405_06;
    localparam logic [79:0] F2  = 80'h74697277_AABBCCDDEE_FF;
    localparam logic [79:0] FB1 = 80'h75697277_0102030405_06;

`ifdef UART_FRAME_STATS_EN
    logic [15:0] ok0, bad0, ok1, bad1;
`endif

    uart_frame_link #(.CSUM(0)) u0 (
        .clk(clk), .rst(rst), .link(if0.slave), .i_tx_data(txd0), .o_rx_data(rxd0),
        .o_sync(sync0), .o_tx_enable(en0), .o_err(err0)
`ifdef UART_FRAME_STATS_EN
        , .o_frames_ok(ok0), .o_frames_bad(bad0)
`endif
    );

    uart_frame_link u1 (
        .clk(clk), .rst(rst), .link(if1.slave), .i_tx_data(txd1), .o_rx_data(rxd1),
        .o_sync(sync1), .o_tx_enable(en1), .o_err(err1)
`ifdef UART_FRAME_STATS_EN
        , .o_frames_ok(ok1), .o_frames_bad(bad1)
`endif
    );

    // Transmitter models: accept tx_start when idle, stay busy for 3 cycles, record the byte.
    initial begin : tx_model0
        int hold;
        hold = 0;
        if0.tx_busy = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (sync0) nsync0++;
            if (rst) begin if0.tx_busy = 1'b0; hold = 0; end
            else if (hold > 0) begin hold--; if (hold == 0) if0.tx_busy = 1'b0; end
            else if (if0.tx_start) begin q0.push_back(if0.tx_byte); if0.tx_busy = 1'b1; hold = 3; end
        end
    end

    initial begin : tx_model1
        int hold;
        hold = 0;
        if1.tx_busy = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (sync1) nsync1++;
            if (rst) begin if1.tx_busy = 1'b0; hold = 0; end
            else if (hold > 0) begin hold--; if (hold == 0) if1.tx_busy = 1'b0; end
            else if (if1.tx_start) begin q1.push_back(if1.tx_byte); if1.tx_busy = 1'b1; hold = 3; end
        end
    end

    task automatic check(input string tag, input logic [103:0] got, input logic [103:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input int d, input logic [7:0] b, input logic eop);
        @(negedge clk);
        if (d == 0) begin if0.rx_byte = b; if0.rx_byte_valid = 1'b1; if0.rx_eop = eop; end
        else        begin if1.rx_byte = b; if1.rx_byte_valid = 1'b1; if1.rx_eop = eop; end
        @(negedge clk);
        if0.rx_byte_valid = 1'b0; if0.rx_eop = 1'b0;
        if1.rx_byte_valid = 1'b0; if1.rx_eop = 1'b0;
    endtask

    task automatic frame(input int d, input logic [103:0] f, input int n, input bit eop_last);
        for (int i = 0; i < n; i++) put(d, f[8*(n-i)-1 -: 8], eop_last && i == n - 1);
        if (!eop_last) begin
            @(negedge clk);
            if (d == 0) if0.rx_eop = 1'b1; else if1.rx_eop = 1'b1;
            @(negedge clk);
            if0.rx_eop = 1'b0; if1.rx_eop = 1'b0;
        end
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 300 && (d == 0 ? en0 : en1); i++) @(negedge clk);
        check("tx_enable_drop", d == 0 ? en0 : en1, 0);
    endtask

    initial begin
        txd0 = 80'hA1A2A3A4A5A6A7A8A9AA;
        txd1 = 80'hA1A2A3A4A5A6A7A8A9AA;
        if0.rx_byte = '0; if0.rx_byte_valid = 1'b0; if0.rx_eop = 1'b0;
        if1.rx_byte = '0; if1.rx_byte_valid = 1'b0; if1.rx_eop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_err0", err0, 0);
        check("rst_sync0", sync0, 0);
        check("rst_en0", en0, 0);
        check("rst_start0", if0.tx_start, 0);
        check("rst_rxd0", rxd0, 0);
        check("rst_err1", err1, 0);
        check("rst_en1", en1, 0);
        rst = 1'b0;
        // valid CSUM=0 frame, eop in its own cycle
        frame(0, {24'h0, F0}, 10, 0);
        check("a_sync", sync0, 1);
        check("a_rxd", rxd0, {24'h0, F0});
        check("a_err", err0, 0);
        check("a_en", en0, 1);
        check("a_start_early", if0.tx_start, 0);
        @(negedge clk);
        check("a_start_lat", if0.tx_start, 1);
        check("a_sync_pulse", sync0, 0);
        wait_done(0);
        check("a_nbytes", q0.size(), 10);
        for (int i = 0; i < 10; i++) check("a_reply", q0[i], txd0[8*(10-i)-1 -: 8]);
        check("a_nsync", nsync0, 1);
        q0.delete();
        // CSUM=1 frame with trailer off by one, eop together with the last byte
        frame(1, {8'h0, F0, 16'h01DC}, 12, 1);
        check("b_err", err1, 2);
        check("b_sync", sync1, 0);
        check("b_en", en1, 0);
        repeat (5) @(negedge clk);
        check("b_nstart", q1.size(), 0);
        check("b_start", if1.tx_start, 0);
        check("b_nsync", nsync1, 0);
        check("b_rxd", rxd1, 0);
        // correct trailer: 0x74+0x69+0x72+0x77+1+2+3+4+5+6 = 0x01DB
        frame(1, {8'h0, F0, 16'h01DB}, 12, 1);
        check("c_sync", sync1, 1);
        check("c_rxd", rxd1, {24'h0, F0});
        check("c_err", err1, 0);
        wait_done(1);
        check("c_nbytes", q1.size(), 12);
        for (int i = 0; i < 12; i++) check("c_reply", q1[i], {txd1, 16'h0677}[8*(12-i)-1 -: 8]);
        q1.delete();
        // bad MSGID
        frame(0, {24'h0, FB1}, 10, 0);
        check("d_err", err0, 1);
        check("d_rxd", rxd0, {24'h0, F0});
        check("d_sync", sync0, 0);
        check("d_en", en0, 0);
        // five bytes then a long gap
        for (int i = 0; i < 5; i++) put(0, F0[8*(10-i)-1 -: 8], 1'b0);
        repeat (1150) @(negedge clk);
        check("e_err_pending", err0, 1);
        repeat (51) @(negedge clk);
        check("e_err_timeout", err0, 3);
        frame(0, {24'h0, F2}, 10, 0);
        check("e_sync", sync0, 1);
        check("e_rxd", rxd0, {24'h0, F2});
        check("e_err_clear", err0, 0);
        wait_done(0);
        q0.delete();
        // reset during the reply
        frame(0, {24'h0, F0}, 10, 0);
        for (int i = 0; i < 300 && q0.size() < 4; i++) @(negedge clk);
        check("f_reached4", q0.size(), 4);
        rst = 1'b1;
        @(negedge clk);
        check("f_start", if0.tx_start, 0);
        check("f_en", en0, 0);
        check("f_rxd", rxd0, 0);
        check("f_txbyte", if0.tx_byte, 0);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        txd0 = 80'h0F1E2D3C4B5A69788796;
        frame(0, {24'h0, F0}, 10, 0);
        check("f_sync", sync0, 1);
        wait_done(0);
        check("f_nbytes", q0.size(), 10);
        check("f_first", q0[0], 8'h0F);
        check("f_last", q0[9], 8'h96);
        // three good, two bad on u1; the last good frame carries an extra ignored byte
        base = nsync1;
        frame(1, {8'h0, F0, 16'h01DB}, 12, 1);
        wait_done(1);
        frame(1, {8'h0, F0, 16'h01DC}, 12, 1);
        check("g_csum", err1, 2);
        frame(1, {8'h0, F0, 16'h01DB}, 12, 1);
        wait_done(1);
        frame(1, {16'h0, F0, 8'h01}, 11, 1);
        check("g_short", err1, 3);
        frame(1, {F0, 16'h01DB, 8'h55}, 13, 1);
        check("g_extra_err", err1, 0);
        check("g_extra_rxd", rxd1, {24'h0, F0});
        wait_done(1);
        check("g_nsync", nsync1 - base, 3);
        check("g_nbytes", q1.size(), 36);
`ifdef UART_FRAME_STATS_EN
        check("g_ok1", ok1, 3);
        check("g_bad1", bad1, 2);
        check("g_ok0", ok0, 1);
        check("g_bad0", bad0, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
